buzzer_sequencer: RTL
=====================

Name: buzzer_sequencer

Overview:
- Command initiator for the buzzer peripheral: queues (note, duration) pairs written by the CPU and plays them autonomously.
- Emits 24-bit buzzer command words plus one-cycle start strobes. Opcodes are in [23:16]: NOP=0, SET=1 (note in [5:0]), STOP=2.
- Sits between the CPU I/O bus and the buzzer's in/start inputs, so software no longer has to time notes itself.

Parameters:
- DEPTH, 8, FIFO entries; power of two, minimum 2.
- TICK_DIV, 50000, clk cycles per duration tick (1 ms at 50 MHz); minimum 2.
- DUR_W, 8, duration field width in ticks.

Ports:
- clk  in  1  clock.
- rst  in  1  reset; asynchronous, active-high.
- wr_en  in  1  push wr_data into FIFO.
- wr_data  in  DUR_W+6  {dur[DUR_W-1:0], note[5:0]}.
- flush  in  1  synchronous abort: empty FIFO, silence buzzer.
- full  out  1  FIFO holds DEPTH entries.
- level  out  clog2(DEPTH)+1  FIFO occupancy.
- overflow  out  1  sticky; set when a write is dropped.
- busy  out  1  state != IDLE or level != 0.
- cmd_out  out  24  command word to buzzer.
- cmd_start  out  1  one-cycle strobe qualifying cmd_out.
- done  out  1  one-cycle pulse when the STOP command is issued.

Behaviour:
- Reset: FIFO empty; state IDLE. All outputs 0: cmd_out, cmd_start, done, overflow, full, level, busy. No STOP is emitted on reset.
- All outputs are registered. cmd_out = 24'd0 (NOP) in every cycle where cmd_start = 0.
- Write acceptance:
  - A write is accepted when wr_en=1 and (level < DEPTH or a pop occurs in the same cycle).
  - Otherwise the write is dropped and overflow is set.
  - A write in the same cycle as flush is dropped, and overflow is not set.
- FSM states:
  - IDLE: if level != 0, go to LOAD next cycle.
  - LOAD (1 cycle): pop the head entry.
    - dur != 0: cmd_out = {8'd1, 10'd0, note}, cmd_start = 1. Duration counter <= dur, prescaler <= 0. Next state PLAY.
    - dur == 0: entry is discarded and no command is issued. Next state is LOAD if FIFO is still non-empty after the pop, else STOP.
  - PLAY: prescaler counts 0..TICK_DIV-1 and wraps. On each wrap the duration counter decrements.
    - When a wrap takes the counter to 0: go to LOAD if FIFO is non-empty (legato, no STOP between notes), else STOP.
    - Resulting timing: SET strobe at cycle t, next strobe at t + 1 + dur*TICK_DIV.
  - STOP (1 cycle): cmd_out = {8'd2, 16'd0}, cmd_start = 1, done = 1. Next state IDLE.
- Note values 0, 1 and 63 are forwarded unchanged; the buzzer holds its output high for these codes.
- Flush:
  - FIFO is cleared in the same cycle; overflow is cleared.
  - In LOAD or PLAY: next state is STOP, which emits STOP/done.
  - In IDLE: stays IDLE, no command issued.
  - In STOP: completes normally.
  - A flush in the LOAD cycle still lets that cycle's SET strobe go out, followed immediately by STOP.
- Async reset mid-note: immediate return to the reset state. Prescaler and duration counter are cleared.
- Width rules: duration counter is DUR_W bits. Prescaler is clog2(TICK_DIV) bits with an explicit compare to TICK_DIV-1, never relying on natural wrap.

Test Plan:
- TICK_DIV=4. Write {dur=3, note=5} → after 2 cycles cmd_start=1 with cmd_out=0x010005. 13 cycles after that strobe: cmd_out=0x020000, cmd_start=1, done=1. busy falls the cycle after.
- Write three notes (dur 1, 2, 1; notes 10, 20, 30) back-to-back → SET strobes spaced 5, 9, then STOP 5 cycles later; no STOP between notes; level decrements per LOAD.
- With playback stalled by one long note (dur=255), write 9 entries with DEPTH=8 → full=1 after the 8th accepted write, 9th dropped, overflow=1, level=8.
- Flush mid-PLAY → next cycle STOP strobe (0x020000) with done=1; level=0; overflow=0; no further SET.
- Entry with dur=0 between two valid notes → no command for it; second SET follows the first after exactly dur1*TICK_DIV+2 cycles.
- Assert rst mid-PLAY for 1 cycle → all outputs 0 immediately; no STOP; a subsequent write plays normally from prescaler 0.

Source files
------------

// File: rtl/buzzer_sequencer_if.sv
// buzzer_sequencer_if: CPU write/flush port, FIFO status and buzzer command port of buzzer_sequencer.
interface buzzer_sequencer_if #(
    parameter int DEPTH = 8,
    parameter int DUR_W = 8
);
    logic                     wr_en;
    logic [DUR_W+5:0]         wr_data;
    logic                     flush;
    logic                     full;
    logic [$clog2(DEPTH):0]   level;
    logic                     overflow;
    logic                     busy;
    logic [23:0]              cmd_out;
    logic                     cmd_start;
    logic                     done;
    modport master (output wr_en, wr_data, flush, input full, level, overflow, busy, cmd_out, cmd_start, done);
    modport slave  (input wr_en, wr_data, flush, output full, level, overflow, busy, cmd_out, cmd_start, done);
endinterface

// File: rtl/buzzer_sequencer.sv
// buzzer_sequencer: queues {dur, note} pairs and plays them as buzzer SET/STOP command strobes.
module buzzer_sequencer #(
    parameter int DEPTH    = 8,
    parameter int TICK_DIV = 50000,
    parameter int DUR_W    = 8
) (
    input logic               clk,
    input logic               rst,
    buzzer_sequencer_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int PW = $clog2(TICK_DIV);
    localparam logic [1:0] IDLE = 2'd0, LOAD = 2'd1, PLAY = 2'd2, STOP = 2'd3;
    logic [1:0]       state, state_n;
    logic [DUR_W+5:0] mem [DEPTH];
    logic [AW-1:0]    rd_ptr, wr_ptr;
    logic [AW:0]      level, level_n;
    logic [PW-1:0]    presc;
    logic [DUR_W-1:0] dur_cnt, head_dur;
    logic [DUR_W+5:0] head;
    logic             pop, push, wrap;
    assign head     = mem[rd_ptr];
    assign head_dur = head[DUR_W+5:6];
    assign pop      = (state == LOAD) && (level != '0);
    assign push     = bus.wr_en && !bus.flush && ((level < (AW+1)'(DEPTH)) || pop);
    assign wrap     = presc == PW'(TICK_DIV - 1);
    assign level_n  = bus.flush ? '0 : level + (AW+1)'(push) - (AW+1)'(pop);
    assign bus.level = level;
    always_comb begin
        state_n = IDLE;
        case (state)
            IDLE: state_n = (level != '0 && !bus.flush) ? LOAD : IDLE;
            LOAD: state_n = bus.flush ? STOP : (head_dur != '0) ? PLAY : (level_n != '0) ? LOAD : STOP;
            PLAY: state_n = bus.flush ? STOP : (wrap && dur_cnt == DUR_W'(1)) ? ((level_n != '0) ? LOAD : STOP) : PLAY;
            default: state_n = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= bus.wr_data;
    end
    // busy reflects the pre-edge state, so it drops one cycle after the STOP strobe
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            rd_ptr        <= '0;
            wr_ptr        <= '0;
            level         <= '0;
            presc         <= '0;
            dur_cnt       <= '0;
            bus.full      <= 1'b0;
            bus.overflow  <= 1'b0;
            bus.busy      <= 1'b0;
            bus.cmd_out   <= '0;
            bus.cmd_start <= 1'b0;
            bus.done      <= 1'b0;
        end else begin
            state         <= state_n;
            level         <= level_n;
            rd_ptr        <= bus.flush ? '0 : rd_ptr + AW'(pop);
            wr_ptr        <= bus.flush ? '0 : wr_ptr + AW'(push);
            presc         <= (state == PLAY && !wrap) ? presc + PW'(1) : '0;
            dur_cnt       <= pop ? head_dur : (state == PLAY && wrap) ? dur_cnt - DUR_W'(1) : dur_cnt;
            bus.full      <= level_n == (AW+1)'(DEPTH);
            bus.overflow  <= !bus.flush && (bus.overflow || (bus.wr_en && !push));
            bus.busy      <= (state != IDLE) || (level != '0);
            bus.cmd_start <= (pop && head_dur != '0) || state == STOP;
            bus.cmd_out   <= (pop && head_dur != '0) ? {8'd1, 10'd0, head[5:0]} : (state == STOP) ? {8'd2, 16'd0} : '0;
            bus.done      <= state == STOP;
        end
    end
endmodule
